// File: rtl/uart_rx_apb_poller_if.sv
// APB link between the RX poller (master) and the UART receiver register block (slave).
// Zero-wait slave: no pready, read data is valid during the ACCESS cycle.
interface uart_rx_apb_poller_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/uart_rx_apb_poller.sv
// APB master that programs the UART RX block, polls it, and queues received bytes with error tags.
// Optional: define UART_RX_POLLER_DROP_ERR_EN to discard errored bytes and count them in err_drop_cnt_o.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | bus idle, waiting for cfg_start or enable
// CFG_BP0   | write bit_period[7:0] to addr 2
// CFG_BP1   | write bit_period[13:8] to addr 3
// CFG_DS    | write data_size to addr 4
// POLL      | read status (addr 0)
// RD_ERR    | read error code (addr 1)
// RD_DATA   | read rx data (addr 6), push into FIFO
// GAP       | bus idle for POLL_GAP cycles
// FULL_WAIT | byte pending but FIFO full, wait for space
module uart_rx_apb_poller #(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_GAP   = 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        cfg_start_i,
  input  logic [13:0]                 cfg_bit_period_i,
  input  logic [3:0]                  cfg_data_size_i,
  input  logic                        enable_i,
  output logic                        configured_o,
  output logic                        busy_o,
  output logic                        bus_err_o,
  uart_rx_apb_poller_if.master        apb,
  output logic [7:0]                  rx_byte_o,
  output logic [1:0]                  rx_err_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic [7:0]                  err_drop_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(POLL_GAP);

  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_BP0   = 4'd1;
  localparam logic [3:0] S_CFG_BP1   = 4'd2;
  localparam logic [3:0] S_CFG_DS    = 4'd3;
  localparam logic [3:0] S_POLL      = 4'd4;
  localparam logic [3:0] S_RD_ERR    = 4'd5;
  localparam logic [3:0] S_RD_DATA   = 4'd6;
  localparam logic [3:0] S_GAP       = 4'd7;
  localparam logic [3:0] S_FULL_WAIT = 4'd8;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_ERR    = 3'd1;
  localparam logic [2:0] A_BP_LO  = 3'd2;
  localparam logic [2:0] A_BP_HI  = 3'd3;
  localparam logic [2:0] A_DSIZE  = 3'd4;
  localparam logic [2:0] A_DATA   = 3'd6;

  logic [3:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [13:0]   cfg_bp_q, cfg_bp_d;
  logic [3:0]    cfg_ds_q, cfg_ds_d;
  logic [1:0]    err_q, err_d;
  logic          configured_q, configured_d;
  logic          bus_err_q, bus_err_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [2:0]    paddr_q, paddr_d;
  logic [7:0]    pwdata_q, pwdata_d;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          start_xfer;
  logic [2:0]    st_addr;
  logic          st_write;
  logic [7:0]    st_wdata;
  logic          xfer_state;
  logic          acc_done;
  logic          has_space;
  logic          data_done;
  logic          cfg_clr;
  logic          push;
  logic          pop;

  assign xfer_state = (state_q == S_CFG_BP0) || (state_q == S_CFG_BP1) ||
                      (state_q == S_CFG_DS)  || (state_q == S_POLL)    ||
                      (state_q == S_RD_ERR)  || (state_q == S_RD_DATA);
  // phase_q=1 marks the ACCESS cycle; its closing edge samples prdata/pslverr
  assign acc_done   = xfer_state && phase_q;
  assign has_space  = count_q < CW'(FIFO_DEPTH);
  assign data_done  = (state_q == S_RD_DATA) && phase_q;
  assign cfg_clr    = (state_q == S_IDLE) && cfg_start_i;
  assign pop        = rx_valid_o && rx_ready_i;

  always_comb begin
    state_d      = state_q;
    phase_d      = 1'b0;
    gap_d        = gap_q;
    cfg_bp_d     = cfg_bp_q;
    cfg_ds_d     = cfg_ds_q;
    err_d        = err_q;
    configured_d = configured_q;
    bus_err_d    = bus_err_q;
    start_xfer   = 1'b0;
    st_addr      = 3'd0;
    st_write     = 1'b0;
    st_wdata     = 8'd0;
    if (acc_done && apb.pslverr) bus_err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          state_d      = S_CFG_BP0;
          cfg_bp_d     = cfg_bit_period_i;
          cfg_ds_d     = cfg_data_size_i;
          configured_d = 1'b0;
          bus_err_d    = 1'b0;
          start_xfer   = 1'b1;
          st_addr      = A_BP_LO;
          st_write     = 1'b1;
          st_wdata     = cfg_bit_period_i[7:0];
        end else if (enable_i && configured_q) begin
          state_d    = S_POLL;
          start_xfer = 1'b1;
          st_addr    = A_STATUS;
        end
      end
      S_CFG_BP0: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d    = S_CFG_BP1;
          start_xfer = 1'b1;
          st_addr    = A_BP_HI;
          st_write   = 1'b1;
          st_wdata   = {2'b00, cfg_bp_q[13:8]};
        end
      end
      S_CFG_BP1: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d    = S_CFG_DS;
          start_xfer = 1'b1;
          st_addr    = A_DSIZE;
          st_write   = 1'b1;
          st_wdata   = {4'b0000, cfg_ds_q};
        end
      end
      S_CFG_DS: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d      = S_IDLE;
          configured_d = 1'b1;
        end
      end
      S_POLL: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (!apb.prdata[0]) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (has_space) begin
          state_d    = S_RD_ERR;
          start_xfer = 1'b1;
          st_addr    = A_ERR;
        end else begin
          state_d = S_FULL_WAIT;
        end
      end
      S_RD_ERR: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          err_d      = apb.prdata[1:0];
          state_d    = S_RD_DATA;
          start_xfer = 1'b1;
          st_addr    = A_DATA;
        end
      end
      S_RD_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (enable_i) begin
          state_d    = S_POLL;
          start_xfer = 1'b1;
          st_addr    = A_STATUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FULL_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (has_space) begin
          state_d    = S_POLL;
          start_xfer = 1'b1;
          st_addr    = A_STATUS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are computed one cycle ahead so every APB pin comes straight from a flop
  assign psel_d    = start_xfer || (xfer_state && !phase_q);
  assign penable_d = xfer_state && !phase_q;
  assign pwrite_d  = start_xfer ? st_write : pwrite_q;
  assign paddr_d   = start_xfer ? st_addr  : paddr_q;
  assign pwdata_d  = start_xfer ? st_wdata : pwdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      gap_q        <= '0;
      cfg_bp_q     <= '0;
      cfg_ds_q     <= '0;
      err_q        <= '0;
      configured_q <= 1'b0;
      bus_err_q    <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      gap_q        <= gap_d;
      cfg_bp_q     <= cfg_bp_d;
      cfg_ds_q     <= cfg_ds_d;
      err_q        <= err_d;
      configured_q <= configured_d;
      bus_err_q    <= bus_err_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

`ifdef UART_RX_POLLER_DROP_ERR_EN
  logic [7:0] drop_q;

  assign push = data_done && (err_q == 2'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_q <= '0;
    end else if (cfg_clr) begin
      drop_q <= '0;
    end else if (data_done && (err_q != 2'd0) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign err_drop_cnt_o = drop_q;
`else
  assign push           = data_done;
  assign err_drop_cnt_o = 8'd0;
`endif

  // Space is checked once per status poll, so push never lands on a full FIFO
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= {err_q, apb.prdata};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign apb.psel     = psel_q;
  assign apb.penable  = penable_q;
  assign apb.pwrite   = pwrite_q;
  assign apb.paddr    = paddr_q;
  assign apb.pwdata   = pwdata_q;

  assign configured_o = configured_q;
  assign busy_o       = state_q != S_IDLE;
  assign bus_err_o    = bus_err_q;
  assign rx_byte_o    = mem_q[rptr_q][7:0];
  assign rx_err_o     = mem_q[rptr_q][9:8];
  assign rx_valid_o   = count_q != '0;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_rx_apb_poller.sv
// Bench for uart_rx_apb_poller: behavioural UART RX slave plus a byte-stream model of the FIFO output.
module tb_uart_rx_apb_poller;
  localparam int FIFO_DEPTH = 4;
  localparam int POLL_GAP   = 2;
  localparam int PERIOD     = 2 + POLL_GAP;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [13:0] cfg_bit_period = '0;
  logic [3:0]  cfg_data_size = '0;
  logic        enable = 1'b0;
  logic        configured, busy, bus_err;
  logic [7:0]  rx_byte;
  logic [1:0]  rx_err;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic [7:0]  err_drop_cnt;

  always #5 clk = ~clk;

  uart_rx_apb_poller_if apb();

  uart_rx_apb_poller #(.FIFO_DEPTH(FIFO_DEPTH), .POLL_GAP(POLL_GAP)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .cfg_start_i      (cfg_start),
    .cfg_bit_period_i (cfg_bit_period),
    .cfg_data_size_i  (cfg_data_size),
    .enable_i         (enable),
    .configured_o     (configured),
    .busy_o           (busy),
    .bus_err_o        (bus_err),
    .apb              (apb),
    .rx_byte_o        (rx_byte),
    .rx_err_o         (rx_err),
    .rx_valid_o       (rx_valid),
    .rx_ready_i       (rx_ready),
    .fifo_count_o     (fifo_count),
    .err_drop_cnt_o   (err_drop_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Slave: a ring of pending {err, data} bytes; status=1 while any is pending
  logic [9:0] slv_mem [256];
  int         slv_wr = 0;
  int         slv_rd = 0;
  logic       force_err = 1'b0;
  logic [2:0] force_addr = 3'd0;
  logic       slv_has;
  logic [9:0] slv_head;

  assign slv_has  = slv_rd != slv_wr;
  assign slv_head = slv_mem[slv_rd % 256];
  assign apb.prdata = (apb.psel && apb.penable && !apb.pwrite) ?
                      ((apb.paddr == 3'd0) ? {7'd0, slv_has} :
                       (apb.paddr == 3'd1) ? {6'd0, (slv_has ? slv_head[9:8] : 2'd0)} :
                       (apb.paddr == 3'd6) ? slv_head[7:0] : 8'd0) : 8'd0;
  assign apb.pslverr = force_err && apb.psel && apb.penable && (apb.paddr == force_addr);

  int         log_cyc [$];
  logic [2:0] log_addr [$];
  logic       log_wr [$];
  logic [7:0] log_data [$];
  logic       prev_setup = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n_rst && apb.psel && apb.penable) begin
      checks++;
      if (!prev_setup) begin
        errors++;
        $display("FAIL apb_setup_before_access: access at cycle %0d without SETUP", cyc + 1);
      end
      log_cyc.push_back(cyc + 1);
      log_addr.push_back(apb.paddr);
      log_wr.push_back(apb.pwrite);
      log_data.push_back(apb.pwdata);
      if (!apb.pwrite && apb.paddr == 3'd6 && slv_has) slv_rd <= slv_rd + 1;
    end
    prev_setup <= n_rst && apb.psel && !apb.penable;
  end

  // Reference stream: bytes offered to the slave, minus those the drop feature discards
  logic [9:0] exp_q [$];
  int         exp_drop = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] e, input logic [7:0] d);
    slv_mem[slv_wr % 256] = {e, d};
    slv_wr++;
`ifdef UART_RX_POLLER_DROP_ERR_EN
    if (e != 2'd0) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      exp_q.push_back({e, d});
    end
`else
    exp_q.push_back({e, d});
`endif
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(3);
    checks++;
    if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) begin
      errors++; $display("FAIL reset_apb_ctl: got %b want 000", {apb.psel, apb.penable, apb.pwrite});
    end
    checks++;
    if ({apb.paddr, apb.pwdata} !== 11'd0) begin
      errors++; $display("FAIL reset_apb_addr_data: got %h want 000", {apb.paddr, apb.pwdata});
    end
    checks++;
    if ({configured, busy, bus_err, rx_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b want 0000", {configured, busy, bus_err, rx_valid});
    end
    checks++;
    if ({fifo_count, rx_err, rx_byte, err_drop_cnt} !== 21'd0) begin
      errors++; $display("FAIL reset_fifo: got %h want 0", {fifo_count, rx_err, rx_byte, err_drop_cnt});
    end
    n_rst = 1'b1;
    enable = 1'b1;
    tick(4);
    checks++;
    if ({busy, apb.psel} !== 2'b00) begin
      errors++; $display("FAIL unconfigured_idle: busy/psel got %b want 00", {busy, apb.psel});
    end
    enable = 1'b0;
  endtask

  task automatic test_config(input logic [13:0] bp, input logic [3:0] ds);
    int base, t0, k;
    logic [7:0] exp_d [3];
    logic [2:0] exp_a [3];
    exp_d[0] = bp[7:0];
    exp_d[1] = {2'b00, bp[13:8]};
    exp_d[2] = {4'b0000, ds};
    exp_a[0] = 3'd2; exp_a[1] = 3'd3; exp_a[2] = 3'd4;
    base = log_addr.size();
    cfg_bit_period = bp;
    cfg_data_size  = ds;
    cfg_start      = 1'b1;
    t0 = cyc + 1;
    tick(1);
    cfg_start = 1'b0;
    checks++;
    if ({busy, configured, apb.psel, apb.penable} !== 4'b1010) begin
      errors++; $display("FAIL cfg_first_setup: busy/cfgd/psel/penable got %b want 1010",
                         {busy, configured, apb.psel, apb.penable});
    end
    k = 0;
    while (!configured && k < 20) begin tick(1); k++; end
    checks++;
    if (!configured) begin
      errors++; $display("FAIL cfg_timeout: configured got 0 want 1");
    end
    checks++;
    if (log_addr.size() - base !== 3) begin
      errors++; $display("FAIL cfg_xfer_count: got %0d want 3", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({log_wr[base+i], log_addr[base+i], log_data[base+i]} !== {1'b1, exp_a[i], exp_d[i]}) begin
          errors++; $display("FAIL cfg_write%0d: got wr=%0d a=%0d d=%h want wr=1 a=%0d d=%h", i,
                             log_wr[base+i], log_addr[base+i], log_data[base+i], exp_a[i], exp_d[i]);
        end
      end
      checks++;
      if (log_cyc[base] - t0 !== 2 || log_cyc[base+2] - t0 !== 6) begin
        errors++; $display("FAIL cfg_timing: first/last close got +%0d/+%0d want +2/+6",
                           log_cyc[base] - t0, log_cyc[base+2] - t0);
      end
    end
    checks++;
    if ({busy, apb.psel} !== 2'b00) begin
      errors++; $display("FAIL cfg_done_idle: busy/psel got %b want 00", {busy, apb.psel});
    end
  endtask

  task automatic test_idle_poll();
    int base, n;
    base = log_addr.size();
    enable = 1'b1;
    tick(16);
    n = log_addr.size() - base;
    checks++;
    if (n < 3) begin
      errors++; $display("FAIL poll_count: got %0d polls want >=3", n);
    end
    for (int i = base; i < log_addr.size(); i++) begin
      checks++;
      if ({log_wr[i], log_addr[i]} !== 4'd0) begin
        errors++; $display("FAIL poll_addr: got wr=%0d a=%0d want read a=0", log_wr[i], log_addr[i]);
      end
      if (i > base) begin
        checks++;
        if (log_cyc[i] - log_cyc[i-1] !== PERIOD) begin
          errors++; $display("FAIL poll_period: got %0d want %0d", log_cyc[i] - log_cyc[i-1], PERIOD);
        end
      end
    end
    checks++;
    if ({rx_valid, fifo_count} !== 4'd0) begin
      errors++; $display("FAIL poll_fifo_empty: got valid=%0d cnt=%0d want 0/0", rx_valid, fifo_count);
    end
  endtask

  task automatic test_single_byte();
    int base, k, di;
    base = log_addr.size();
    offer(2'd0, 8'h5A);
    k = 0;
    while (!rx_valid && k < 40) begin tick(1); k++; end
    tick(6);
    di = -1;
    for (int i = base + 2; i < log_addr.size(); i++)
      if (di < 0 && log_addr[i] == 3'd6) di = i;
    checks++;
    if (di < 0 || di + 1 >= log_addr.size()) begin
      errors++; $display("FAIL single_seq_found: data read index %0d want a complete sequence", di);
    end else begin
      checks++;
      if ({log_addr[di-2], log_addr[di-1], log_addr[di+1]} !== {3'd0, 3'd1, 3'd0}) begin
        errors++; $display("FAIL single_seq_addr: got %0d,%0d,6,%0d want 0,1,6,0",
                           log_addr[di-2], log_addr[di-1], log_addr[di+1]);
      end
      checks++;
      if (log_cyc[di] - log_cyc[di-2] !== 4 || log_cyc[di+1] - log_cyc[di] !== PERIOD) begin
        errors++; $display("FAIL single_seq_timing: got %0d/%0d want 4/%0d",
                           log_cyc[di] - log_cyc[di-2], log_cyc[di+1] - log_cyc[di], PERIOD);
      end
    end
    checks++;
    if ({rx_valid, rx_err, rx_byte} !== {1'b1, exp_q[0]}) begin
      errors++; $display("FAIL single_head: got v=%0d e=%0d b=%h want v=1 e=%0d b=%h",
                         rx_valid, rx_err, rx_byte, exp_q[0][9:8], exp_q[0][7:0]);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: rx_valid got %0d want 0", rx_valid);
    end
  endtask

  task automatic test_fifo_full();
    int k, base;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) offer(2'd0, 8'(i));
    k = 0;
    while (fifo_count != 3'd4 && k < 100) begin tick(1); k++; end
    tick(8);
    base = log_addr.size();
    tick(10);
    checks++;
    if (log_addr.size() !== base || apb.psel !== 1'b0) begin
      errors++; $display("FAIL full_bus_idle: got %0d new xfers psel=%0d want 0/0",
                         log_addr.size() - base, apb.psel);
    end
    checks++;
    if ({busy, fifo_count} !== {1'b1, 3'd4} || slv_wr - slv_rd !== 1) begin
      errors++; $display("FAIL full_wait_state: got busy=%0d cnt=%0d pending=%0d want 1/4/1",
                         busy, fifo_count, slv_wr - slv_rd);
    end
    checks++;
    if (log_addr[$] !== 3'd0) begin
      errors++; $display("FAIL full_last_poll: got addr %0d want 0", log_addr[$]);
    end
    checks++;
    if ({rx_err, rx_byte} !== exp_q[0]) begin
      errors++; $display("FAIL full_pop_head: got %h want %h", {rx_err, rx_byte}, exp_q[0]);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
    k = 0;
    while (slv_rd != slv_wr && k < 30) begin tick(1); k++; end
    tick(1);
    checks++;
    if (fifo_count !== 3'd4 || slv_rd != slv_wr) begin
      errors++; $display("FAIL full_resume: got cnt=%0d pending=%0d want 4/0", fifo_count, slv_wr - slv_rd);
    end
    rx_ready = 1'b1;
    k = 0;
    while (rx_valid && k < 10) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL full_drain_extra: got %h want nothing", {rx_err, rx_byte});
      end else if ({rx_err, rx_byte} !== exp_q[0]) begin
        errors++; $display("FAIL full_drain: got %h want %h", {rx_err, rx_byte}, exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick(1);
      k++;
    end
    rx_ready = 1'b0;
    checks++;
    if (k !== 4 || exp_q.size() !== 0) begin
      errors++; $display("FAIL full_drain_count: got %0d pops %0d left want 4/0", k, exp_q.size());
    end
  endtask

  task automatic test_error_tag();
    int k;
    offer(2'd1, 8'h77);
    k = 0;
    while (slv_rd != slv_wr && k < 40) begin tick(1); k++; end
    tick(1);
    checks++;
    if (int'(fifo_count) !== exp_q.size() || rx_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL err_tag_count: got cnt=%0d valid=%0d want %0d", fifo_count, rx_valid, exp_q.size());
    end
    checks++;
    if (err_drop_cnt !== 8'(exp_drop)) begin
      errors++; $display("FAIL err_drop_cnt: got %0d want %0d", err_drop_cnt, exp_drop);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if ({rx_err, rx_byte} !== exp_q[0]) begin
        errors++; $display("FAIL err_tag_head: got e=%0d b=%h want e=%0d b=%h",
                           rx_err, rx_byte, exp_q[0][9:8], exp_q[0][7:0]);
      end
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_bus_err();
    int k, base;
    enable = 1'b0;
    k = 0;
    while (busy && k < 30) begin tick(1); k++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL berr_drain_idle: busy got %0d want 0", busy);
    end
    force_err  = 1'b1;
    force_addr = 3'd3;
    base = log_addr.size();
    cfg_bit_period = 14'h0155;
    cfg_data_size  = 4'd7;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    k = 0;
    while (!configured && k < 20) begin tick(1); k++; end
    force_err = 1'b0;
    checks++;
    if ({bus_err, configured, busy} !== 3'b110) begin
      errors++; $display("FAIL berr_set: bus_err/cfgd/busy got %b want 110", {bus_err, configured, busy});
    end
    checks++;
    if (log_addr.size() - base !== 3 || log_addr[$] !== 3'd4) begin
      errors++; $display("FAIL berr_seq_complete: got %0d xfers last a=%0d want 3/4",
                         log_addr.size() - base, log_addr[$]);
    end
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    exp_drop = 0;
    checks++;
    if ({bus_err, configured, err_drop_cnt} !== 10'd0) begin
      errors++; $display("FAIL berr_clear: bus_err/cfgd/drop got %0d/%0d/%0d want 0/0/0",
                         bus_err, configured, err_drop_cnt);
    end
    k = 0;
    while (!configured && k < 20) begin tick(1); k++; end
    checks++;
    if ({bus_err, configured} !== 2'b01) begin
      errors++; $display("FAIL berr_reconfig: bus_err/cfgd got %b want 01", {bus_err, configured});
    end
  endtask

  task automatic test_random();
    int offered, k;
    offered = 0;
    enable  = 1'b1;
    k = 0;
    while (!(offered == 40 && slv_rd == slv_wr && exp_q.size() == 0) && k < 5000) begin
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_ready && rx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_byte: got %h want none", {rx_err, rx_byte});
        end else if ({rx_err, rx_byte} !== exp_q[0]) begin
          errors++; $display("FAIL rand_byte: got %h want %h", {rx_err, rx_byte}, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (offered < 40 && slv_rd == slv_wr && $urandom_range(0, 3) == 0) begin
        offer(2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)));
        offered++;
      end
      tick(1);
      k++;
    end
    rx_ready = 1'b0;
    tick(2);
    checks++;
    if (k >= 5000) begin
      errors++; $display("FAIL rand_timeout: %0d bytes left want 0", exp_q.size());
    end
    checks++;
    if ({fifo_count, rx_valid} !== 4'd0) begin
      errors++; $display("FAIL rand_empty: got cnt=%0d valid=%0d want 0/0", fifo_count, rx_valid);
    end
    checks++;
    if (err_drop_cnt !== 8'(exp_drop) || bus_err !== 1'b0) begin
      errors++; $display("FAIL rand_drop_cnt: got drop=%0d berr=%0d want %0d/0", err_drop_cnt, bus_err, exp_drop);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) slv_mem[i] = '0;
    test_reset();
    test_config(14'h1A2B, 4'h8);
    test_idle_poll();
    test_single_byte();
    test_fifo_full();
    test_error_tag();
    test_bus_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
